sap_obi_demux_tracked: RTL and testbench



---
 rtl/sap_xbar_pkg.sv | 36 +++
 rtl/sap_obi_demux_tracked_err_slave.sv | 29 ++
 rtl/sap_obi_demux_tracked.sv | 116 +++++++++++
 tb/tb_sap_obi_demux_tracked.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_xbar_pkg.sv
// Shared types and constants for the SAP OBI crossbar pieces: address-map rule,
// default OBI request/response structs and the error-responder read data.
package sap_xbar_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADC_AB1E;

    // end_addr is exclusive
    typedef struct packed {
        logic [31:0]   idx;
        logic [AW-1:0] start_addr;
        logic [AW-1:0] end_addr;
    } addr_map_rule_t;

    typedef struct packed {
        logic            req;
        logic            we;
        logic [DW/8-1:0] be;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
    } obi_req_t;

    typedef struct packed {
        logic          gnt;
        logic          rvalid;
        logic [DW-1:0] rdata;
    } obi_resp_t;

    // index width that never collapses to zero bits
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sap_obi_demux_tracked_err_slave.sv
// Internal OBI error responder: always grants, answers each handshake one cycle
// later with a fixed error payload.
module sap_obi_err_slave #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic rvalid_q, rvalid_d;

    always_comb begin
        rvalid_d = req_i;
        gnt_o    = 1'b1;
        rvalid_o = rvalid_q;
        rdata_o  = ERR_RDATA;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rvalid_q <= 1'b0;
        else         rvalid_q <= rvalid_d;
    end

endmodule

// File: rtl/sap_obi_demux_tracked.sv
// 1-to-N OBI demux with outstanding tracking: all in-flight transactions target
// one port, so responses come back in order; unmapped addresses hit an error responder.
module sap_obi_demux_tracked #(
    parameter int unsigned           NUM_SLAVES      = 2,
    parameter int unsigned           NUM_RULES       = NUM_SLAVES,
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           MAX_OUTSTANDING = 4,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA       = DATA_WIDTH'(sap_xbar_pkg::ERR_RDATA_DEFAULT),
    parameter type                   obi_req_t       = sap_xbar_pkg::obi_req_t,
    parameter type                   obi_resp_t      = sap_xbar_pkg::obi_resp_t,
    localparam int unsigned          CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  sap_xbar_pkg::addr_map_rule_t [NUM_RULES-1:0]  addr_map_i,
    input  obi_req_t                                      master_req_i,
    output obi_resp_t                                     master_resp_o,
    output logic                                          master_err_o,
    output obi_req_t  [NUM_SLAVES-1:0]                    slave_req_o,
    input  obi_resp_t [NUM_SLAVES-1:0]                    slave_resp_i,
    output logic [CNT_W-1:0]                              outstanding_o
);

    import sap_xbar_pkg::*;

    localparam int unsigned      IDX_W   = idx_width(NUM_SLAVES + 1);
    localparam logic [IDX_W-1:0] ERR_IDX = IDX_W'(NUM_SLAVES);

    logic [IDX_W-1:0]      dec_idx, cur_idx_q, cur_idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  spurious_q, spurious_d;
    logic                  allow, sel_gnt, hs, pop, cur_rvalid;
    logic [DATA_WIDTH-1:0] cur_rdata;
    logic                  err_req, err_gnt, err_rvalid;
    logic [DATA_WIDTH-1:0] err_rdata;

    // Last matching rule wins; rules pointing past the slave range are ignored.
    always_comb begin
        dec_idx = ERR_IDX;
        for (int unsigned r = 0; r < NUM_RULES; r++) begin
            if (addr_map_i[r].idx < 32'(NUM_SLAVES) &&
                master_req_i.addr[ADDR_WIDTH-1:0] >= addr_map_i[r].start_addr[ADDR_WIDTH-1:0] &&
                master_req_i.addr[ADDR_WIDTH-1:0] <  addr_map_i[r].end_addr[ADDR_WIDTH-1:0])
                dec_idx = IDX_W'(addr_map_i[r].idx);
        end
    end

    always_comb begin
        sel_gnt    = err_gnt;
        cur_rvalid = err_rvalid;
        cur_rdata  = err_rdata;
        spurious_d = spurious_q;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (dec_idx == IDX_W'(i)) sel_gnt = slave_resp_i[i].gnt;
            if (cur_idx_q == IDX_W'(i)) begin
                cur_rvalid = slave_resp_i[i].rvalid;
                cur_rdata  = slave_resp_i[i].rdata;
            end
            if (slave_resp_i[i].rvalid && (cnt_q == '0 || cur_idx_q != IDX_W'(i)))
                spurious_d = 1'b1;
        end
    end

    // A target switch is legal once the last outstanding response pops, even in the same cycle.
    always_comb begin
        pop   = cur_rvalid && (cnt_q != '0);
        allow = (cnt_q < CNT_W'(MAX_OUTSTANDING)) &&
                (cnt_q == '0 || dec_idx == cur_idx_q || (cnt_q == CNT_W'(1) && pop));
        hs      = master_req_i.req && allow && sel_gnt;
        err_req = master_req_i.req && allow && (dec_idx == ERR_IDX);

        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            slave_req_o[i]     = master_req_i;
            slave_req_o[i].req = master_req_i.req && allow && (dec_idx == IDX_W'(i));
        end

        master_resp_o        = '0;
        master_resp_o.gnt    = hs;
        master_resp_o.rvalid = pop;
        master_resp_o.rdata  = cur_rdata;
        master_err_o         = pop && (cur_idx_q == ERR_IDX);

        cnt_d = cnt_q;
        if (hs && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!hs && pop) cnt_d = cnt_q - CNT_W'(1);
        cur_idx_d = hs ? dec_idx : cur_idx_q;
    end

    assign outstanding_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            cur_idx_q  <= '0;
            spurious_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            cur_idx_q  <= cur_idx_d;
            spurious_q <= spurious_d;
        end
    end

    sap_obi_err_slave #(
        .DATA_WIDTH (DATA_WIDTH),
        .ERR_RDATA  (ERR_RDATA)
    ) u_err_slave (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (err_req),
        .gnt_o    (err_gnt),
        .rvalid_o (err_rvalid),
        .rdata_o  (err_rdata)
    );

endmodule

// File: tb/tb_sap_obi_demux_tracked.sv
// Scoreboard bench for sap_obi_demux_tracked: two modelled slaves with programmable
// latency/hold, expected responses queued at master handshake and checked on rvalid.
module tb_sap_obi_demux_tracked;

    import sap_xbar_pkg::*;

    localparam int NS   = 2;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addr_map_rule_t [NS-1:0] amap;
    obi_req_t                m_req;
    obi_resp_t               m_resp;
    logic                    m_err;
    obi_req_t  [NS-1:0]      s_req;
    obi_resp_t [NS-1:0]      s_resp;
    logic [2:0]              outst;

    sap_obi_demux_tracked #(
        .NUM_SLAVES      (NS),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .addr_map_i    (amap),
        .master_req_i  (m_req),
        .master_resp_o (m_resp),
        .master_err_o  (m_err),
        .slave_req_o   (s_req),
        .slave_resp_i  (s_resp),
        .outstanding_o (outst)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int peak    = 0;
    bit rnd     = 1'b0;

    int          lat      [NS];
    logic        hold     [NS];
    logic        force_rv [NS];
    logic        gnt_en   [NS] = '{1'b1, 1'b1};
    logic        rv_rdy   [NS] = '{1'b0, 1'b0};
    logic [31:0] rv_dat   [NS] = '{32'h0, 32'h0};

    typedef struct { int due; logic [31:0] data; } pend_t;
    typedef struct packed { logic err; logic [31:0] data; } exp_t;
    exp_t sb[$];
    int   mseq [NS] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkdata(input int s, input int n, input logic [31:0] a);
        return {s[3:0], n[11:0], a[15:0]};
    endfunction

    function automatic int tgt(input logic [31:0] a);
        if (a < 32'h1000) return 0;
        if (a < 32'h2000) return 1;
        return NS;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Slave models: in-order responses, each due a programmable number of cycles after grant.
    for (genvar g = 0; g < NS; g++) begin : g_slv
        pend_t q[$];
        int    seq = 0;
        always @(negedge clk) begin : slv_mon
            pend_t p;
            if (!rst_n) q.delete();
            else begin
                if (rv_rdy[g] && !hold[g] && q.size() > 0) p = q.pop_front();
                if (s_req[g].req && s_resp[g].gnt) begin
                    p.due  = cyc + lat[g];
                    p.data = mkdata(g, seq, s_req[g].addr);
                    q.push_back(p);
                    seq++;
                end
            end
        end
        always @(posedge clk) begin
            #1;
            rv_rdy[g] = (q.size() > 0) && (q[0].due <= cyc);
            rv_dat[g] = (q.size() > 0) ? q[0].data : 32'h0;
            gnt_en[g] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            s_resp[i].gnt    = gnt_en[i];
            s_resp[i].rvalid = (rv_rdy[i] && !hold[i]) || force_rv[i];
            s_resp[i].rdata  = rv_dat[i];
        end
    end

    // Master-side monitor: pop-and-compare before push so same-cycle pop+issue is ordered.
    always @(negedge clk) begin : mon
        exp_t e;
        int   t;
        if (!rst_n) sb.delete();
        else begin
            if (m_resp.rvalid || (m_req.req && m_resp.gnt))
                chk("outstanding", 32'(outst), 32'(sb.size()));
            if (int'(outst) > peak) peak = int'(outst);
            if (m_resp.rvalid) begin
                if (sb.size() == 0) chk("unexp_rvalid", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("rdata", m_resp.rdata, e.data);
                    chk("err", 32'(m_err), 32'(e.err));
                end
            end
            if (m_req.req && m_resp.gnt) begin
                t = tgt(m_req.addr);
                if (t < NS) begin
                    e.err  = 1'b0;
                    e.data = mkdata(t, mseq[t], m_req.addr);
                    mseq[t]++;
                end else begin
                    e.err  = 1'b1;
                    e.data = 32'hBADCAB1E;
                end
                sb.push_back(e);
                chk("cnt_le_max", 32'(outst <= 3'(MAXO)), 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; holds the request stable until granted.
    task automatic do_req(input logic [31:0] a, input logic w, output int waited);
        m_req.req   = 1'b1;
        m_req.we    = w;
        m_req.be    = 4'hF;
        m_req.addr  = a;
        m_req.wdata = $urandom;
        waited = 0;
        forever begin
            @(negedge clk);
            if (m_resp.gnt) break;
            waited++;
            if (waited > 200) begin
                chk("gnt_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
            #1;
        end
        step();
        m_req.req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [31:0] a;
        amap[0] = '{idx: 32'd0, start_addr: 32'h0000, end_addr: 32'h1000};
        amap[1] = '{idx: 32'd1, start_addr: 32'h1000, end_addr: 32'h2000};
        m_req = '0;
        for (int i = 0; i < NS; i++) begin
            lat[i] = 2; hold[i] = 1'b0; force_rv[i] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 32'(m_resp.gnt), 32'd0);
        chk("rst_rvalid", 32'(m_resp.rvalid), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_cnt", 32'(outst), 32'd0);
        chk("rst_sreq", 32'({s_req[1].req, s_req[0].req}), 32'd0);
        chk("rst_spurious", 32'(dut.spurious_q), 32'd0);
        step();

        // Back-to-back reads to S0, latency 2
        peak = 0;
        for (int k = 0; k < 4; k++) begin
            do_req(32'h10, 1'b0, w);
            chk("b2b_wait", 32'(w), 32'd0);
        end
        drain();
        chk("b2b_peak", 32'(peak), 32'd2);

        // Fill to MAX_OUTSTANDING with responses held back
        hold[0] = 1'b1;
        for (int k = 0; k < MAXO; k++) begin
            do_req(32'h10, 1'b0, w);
            chk("fill_wait", 32'(w), 32'd0);
        end
        m_req.req = 1'b1; m_req.we = 1'b0; m_req.addr = 32'h10;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_gnt", 32'(m_resp.gnt), 32'd0);
            chk("stall_sreq", 32'(s_req[0].req), 32'd0);
            step();
        end
        hold[0] = 1'b0;
        @(negedge clk);
        chk("full_pop_rvalid", 32'(m_resp.rvalid), 32'd1);
        chk("full_pop_gnt", 32'(m_resp.gnt), 32'd0);
        step();
        @(negedge clk);
        chk("refill_gnt", 32'(m_resp.gnt), 32'd1);
        step();
        m_req.req = 1'b0;
        drain();

        // Target switch S0 -> S1 issues on the cycle the last S0 response pops
        lat[0] = 2; lat[1] = 1;
        do_req(32'h10, 1'b0, w);
        m_req.req = 1'b1; m_req.addr = 32'h1010;
        @(negedge clk);
        chk("switch_hold_gnt", 32'(m_resp.gnt), 32'd0);
        chk("switch_hold_sreq1", 32'(s_req[1].req), 32'd0);
        step();
        @(negedge clk);
        chk("switch_pop", 32'(m_resp.rvalid), 32'd1);
        chk("switch_gnt", 32'(m_resp.gnt), 32'd1);
        chk("switch_sreq1", 32'(s_req[1].req), 32'd1);
        step();
        m_req.req = 1'b0;
        drain();

        // Unmapped write goes to the error responder
        m_req.req = 1'b1; m_req.we = 1'b1; m_req.addr = 32'h8000;
        @(negedge clk);
        chk("err_gnt", 32'(m_resp.gnt), 32'd1);
        chk("err_noslave", 32'({s_req[1].req, s_req[0].req}), 32'd0);
        step();
        m_req.req = 1'b0;
        @(negedge clk);
        chk("err_rvalid", 32'(m_resp.rvalid), 32'd1);
        chk("err_rdata", m_resp.rdata, 32'hBADCAB1E);
        chk("err_flag", 32'(m_err), 32'd1);
        step();
        drain();

        // Reset with three outstanding, then a stale response arrives
        hold[0] = 1'b1; lat[0] = 1;
        for (int k = 0; k < 3; k++) do_req(32'h10, 1'b0, w);
        @(negedge clk);
        chk("pre_reset_cnt", 32'(outst), 32'd3);
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        force_rv[0] = 1'b1;
        @(negedge clk);
        chk("stale_rvalid", 32'(m_resp.rvalid), 32'd0);
        chk("stale_cnt", 32'(outst), 32'd0);
        step();
        force_rv[0] = 1'b0;
        @(negedge clk);
        chk("spurious", 32'(dut.spurious_q), 32'd1);
        hold[0] = 1'b0;
        step();

        // Random mix with random latencies and grant stalls
        rnd = 1'b1;
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 4))
                0, 1:    a = {20'h0, 12'($urandom_range(0, 32'hFFF))} & 32'hFFFF_FFFC;
                2, 3:    a = 32'h1000 | ({20'h0, 12'($urandom_range(0, 32'hFFF))} & 32'hFFFF_FFFC);
                default: a = 32'h4000_0000 | 32'($urandom_range(0, 32'hFFFF));
            endcase
            lat[$urandom_range(0, NS - 1)] = $urandom_range(1, 3);
            do_req(a, 1'($urandom_range(0, 1)), w);
            if ($urandom_range(0, 3) == 0) step();
        end
        rnd = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
